nios_system_pio_ext: RTL

Parametrised Avalon-MM parallel I/O slave on the Nios II system bus, replacing the fixed 3-bit output-only PIO. It provides a DATA_WIDTH-bit output register with atomic bit set/clear, and a synchronised input port with per-bit edge capture. It also raises a maskable level interrupt, so software can drive hardware control lines and receive hardware events through one peripheral.

---
 rtl/nios_system_pio_ext.sv | 110 +++++++++++
 1 files changed

// File: rtl/nios_system_pio_ext.sv
// Avalon-MM parallel I/O slave: output register with atomic set/clear, synchronised
// input port with per-bit edge capture, and a maskable level interrupt.
module nios_system_pio_ext #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic [DATA_WIDTH-1:0] irqMask_q, irqMask_d;
    logic [DATA_WIDTH-1:0] edgeCap_q, edgeCap_d;
    logic [DATA_WIDTH-1:0] sync1_q, inSync_q, inPrev_q;
    logic [1:0]            armCnt_q, armCnt_d;

    logic                  wrEn;
    logic                  armed;
    logic [DATA_WIDTH-1:0] wrData;
    logic [DATA_WIDTH-1:0] w1c;
    logic [DATA_WIDTH-1:0] rise, fall, edgeDet;
    logic [DATA_WIDTH-1:0] rdField;

    if (DATA_WIDTH < 32) begin : gUnusedHi
        logic unusedHi;
        assign unusedHi = ^writedata[31:DATA_WIDTH];
    end

    always_comb begin
        wrEn      = chipselect & ~write_n;
        wrData    = writedata[DATA_WIDTH-1:0];
        dataOut_d = dataOut_q;
        irqMask_d = irqMask_q;
        w1c       = '0;
        if (wrEn) begin
            case (address)
                3'd0, 3'd1: dataOut_d = wrData;
                3'd2:       irqMask_d = wrData;
                3'd3:       w1c       = wrData;
                3'd4:       dataOut_d = dataOut_q | wrData;
                3'd5:       dataOut_d = dataOut_q & ~wrData;
                default:    ;
            endcase
        end
    end

    // Edges are ignored until the arm counter saturates, so inputs already high
    // at reset release do not produce a spurious capture.
    always_comb begin
        rise  = inSync_q & ~inPrev_q;
        fall  = ~inSync_q & inPrev_q;
        armed = (armCnt_q == 2'd3);
        if (EDGE_TYPE == 0) begin
            edgeDet = rise;
        end else if (EDGE_TYPE == 1) begin
            edgeDet = fall;
        end else begin
            edgeDet = rise | fall;
        end
        edgeCap_d = (edgeCap_q & ~w1c) | (edgeDet & {DATA_WIDTH{armed}});
        armCnt_d  = armed ? armCnt_q : armCnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataOut_q <= RST_DATA;
            irqMask_q <= '0;
            edgeCap_q <= '0;
            sync1_q   <= '0;
            inSync_q  <= '0;
            inPrev_q  <= '0;
            armCnt_q  <= 2'd0;
        end else begin
            dataOut_q <= dataOut_d;
            irqMask_q <= irqMask_d;
            edgeCap_q <= edgeCap_d;
            sync1_q   <= in_port;
            inSync_q  <= sync1_q;
            inPrev_q  <= inSync_q;
            armCnt_q  <= armCnt_d;
        end
    end

    always_comb begin
        case (address)
            3'd0:    rdField = inSync_q;
            3'd1:    rdField = dataOut_q;
            3'd2:    rdField = irqMask_q;
            3'd3:    rdField = edgeCap_q;
            default: rdField = '0;
        endcase
        readdata                   = '0;
        readdata[DATA_WIDTH-1:0]   = rdField;
    end

    assign out_port = dataOut_q;
    assign irq      = |(edgeCap_q & irqMask_q);

endmodule
